press_pulse_gen: RTL and testbench
==================================

# press_pulse_gen

Input front end for the tug-of-war playfield. It converts raw, asynchronous player buttons into clean single-cycle `L`/`R` press pulses, the only move events the light cells accept. It also hosts the LFSR-driven computer opponent, which can stand in for the right player. Outputs feed every light cell's `L`/`R` inputs directly.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a debounced level changes (legal range 2–255).
- `CPU_PACE`, default 8: clock cycles between computer press attempts (legal range 2–255).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset. State clears on a rising `clk` edge where `reset`=0.
- `key_l`  in  1  raw left-player button, active-high, asynchronous to `clk`, may bounce.
- `key_r`  in  1  raw right-player button, same properties as `key_l`.
- `cpu_en`  in  1  1 = right player driven by computer, `key_r` ignored for output; 0 = human right player.
- `difficulty`  in  9  computer press threshold; larger value means more frequent presses.
- `freeze`  in  1  game over; when 1, `L`=`R`=0.
- `L`  out  1  one-cycle left-press pulse.
- `R`  out  1  one-cycle right-press pulse.

## Operation

- **Synchronizer:** two-flop chain per key (`s1`, `s2`). Reset value 0.
- **Debouncer (per key):** stable level `db` plus counter `cnt`.
  - Each edge with `s2 != db`: if `cnt == DEBOUNCE_CYCLES-1`, then `db <= s2` and `cnt <= 0`; else `cnt <= cnt+1`.
  - Any edge with `s2 == db`: `cnt <= 0`.
  - Reset: `db`=0, `cnt`=0.
- **Edge detect:** `db_d` is `db` delayed one cycle. `rise = db & ~db_d`. A held key yields exactly one pulse; a release yields none.
- **LFSR:** 10-bit `q`, reset 0x000, advances every cycle, including during `freeze` and `cpu_en`=0.
  - Update: `q <= {q[8:0], ~(q[9]^q[6])}`.
  - The all-ones state is the lockup state and is unreachable from reset.
- **Computer player:**
  - Pace counter `pc` counts 0..`CPU_PACE-1` and wraps; reset 0.
  - On the edge where `pc == CPU_PACE-1`, `cpu_hit <= (q < {1'b0,difficulty})`. On every other edge, `cpu_hit <= 0`.
  - `cpu_hit` therefore lasts exactly one cycle. `difficulty`=0 never presses.
- **Right source:** `r_req = cpu_en ? cpu_hit : rise_r`. `l_req = rise_l`.
- **Conflict:** if `l_req` and `r_req` are both 1 in the same cycle, both are dropped (pushes cancel). Neither is retried.
- **Output:** `L = l_req & ~r_req & ~freeze`; `R = r_req & ~l_req & ~freeze`.
- **Freeze:** masks outputs only; internal state keeps running. Releasing `freeze` while a key is held produces no pulse, because the edge was already consumed.
- **Reset mid-operation:** all registers clear on that edge. A key held across reset release produces one pulse once it has been re-synchronized and debounced.
- **`cpu_en` changes:** take effect combinationally; no state is cleared.

## Timing

- Reset values: `L`=0, `R`=0, `q`=0x000, `pc`=0, `cpu_hit`=0, all `s1`/`s2`/`db`/`db_d`/`cnt`=0.
- Human latency: `key_l` first sampled 1 at edge n and held → `db` set at edge n+1+`DEBOUNCE_CYCLES` → `L` high for the single cycle after that edge.
  - With the default of 4, `L` is high between edges n+5 and n+6.
- Glitch rejection: a pulse shorter than `DEBOUNCE_CYCLES` cycles at `s2` never changes `db`.
- Computer latency: `R` is high during the cycle after a terminal-count edge whose compare passed.
- Combinational paths exist from `freeze` and `cpu_en` to the outputs. All other output logic is driven from registers only.
- At most one of `L`/`R` is high in any cycle. Each pulse is exactly one cycle wide.

## Test plan

- **Reset:** hold `reset`=0 for 3 cycles with keys toggling → `L`=`R`=0 throughout. After release, `q` reads 0x000, 0x001, 0x003, 0x007, 0x00F on successive cycles.
- **Clean press:** default parameters; `key_l`=1 sampled from edge 10, held 20 cycles → `L`=1 only between edges 15 and 16. No second pulse on hold or on release.
- **Bounce:** `key_l` high for 3 cycles, low for 2, then high for 10 → exactly one `L` pulse, 5 cycles after the final rise is sampled. The 3-cycle glitch alone produces none.
- **Cancel:** `key_l` and `key_r` rise on the same edge, with `cpu_en`=0 → no pulse on either output. A later lone `key_r` press → one `R` pulse.
- **Computer:** `cpu_en`=1 and `difficulty`=0 for 1000 cycles → `R` never asserts. With `difficulty`=511, `R` pulses only in the cycle after `pc`=7, with a hit rate near 50% over 1024 attempts. `key_r` presses are ignored.
- **Freeze:** `freeze`=1, press `key_l` → no `L`. Drop `freeze` while `key_l` is still held → no `L`. Release, then press again → one `L`.

Source files
------------

// File: rtl/press_pulse_gen.sv
// Player input front end: synchronizes and debounces the two raw buttons, turns
// debounced rises into one-cycle L/R move pulses, and hosts the LFSR computer opponent.
module press_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CPU_PACE        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_l,
  input  logic       key_r,
  input  logic       cpu_en,
  input  logic [8:0] difficulty,
  input  logic       freeze,
  output logic       L,
  output logic       R
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] PC_LAST = 8'(CPU_PACE - 1);

  // Bit 0 carries the left key, bit 1 the right key.
  logic [1:0]      keys;
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      db;
  logic [1:0]      db_d;
  logic [1:0]      rise;
  logic [1:0][7:0] cnt;

  logic [9:0] q;
  logic [7:0] pc;
  logic       cpu_hit;
  logic       l_req;
  logic       r_req;

  assign keys = {key_r, key_l};

  // Two-flop synchronizer
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
    end
  end

  // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (!reset) begin
      db   <= '0;
      db_d <= '0;
      cnt  <= '0;
    end else begin
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != db[i]) begin
          if (cnt[i] == DB_LAST) begin
            db[i]  <= s2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Computer opponent: XNOR LFSR free-runs; a press is attempted once per pace period
  always_ff @(posedge clk) begin
    if (!reset) begin
      q       <= '0;
      pc      <= '0;
      cpu_hit <= 1'b0;
    end else begin
      q <= {q[8:0], ~(q[9] ^ q[6])};
      if (pc == PC_LAST) begin
        pc      <= '0;
        cpu_hit <= (q < {1'b0, difficulty});
      end else begin
        pc      <= pc + 8'd1;
        cpu_hit <= 1'b0;
      end
    end
  end

  // Simultaneous pushes cancel; freeze only masks, it never stalls state
  assign rise  = db & ~db_d;
  assign l_req = rise[0];
  assign r_req = cpu_en ? cpu_hit : rise[1];
  assign L     = l_req & ~r_req & ~freeze;
  assign R     = r_req & ~l_req & ~freeze;

endmodule

// File: tb/tb_press_pulse_gen.sv
// Directed bench for press_pulse_gen: reset, debounce latency, bounce rejection,
// cancel, freeze masking and the LFSR computer opponent against a small reference model.
module tb_press_pulse_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_l = 1'b0;
  logic       key_r = 1'b0;
  logic       cpu_en = 1'b0;
  logic [8:0] difficulty = 9'd0;
  logic       freeze = 1'b0;
  logic       L;
  logic       R;

  int checks = 0;
  int fails  = 0;

  press_pulse_gen #(.DEBOUNCE_CYCLES(4), .CPU_PACE(8)) dut (
    .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r), .cpu_en(cpu_en),
    .difficulty(difficulty), .freeze(freeze), .L(L), .R(R)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      key_l = k[0];
      key_r = ~k[0];
      step();
      checks++;
      if (L !== 1'b0 || R !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: L=%b R=%b, required 0 0", k, L, R);
      end
    end
    key_l = 1'b0;
    key_r = 1'b0;
    checks++;
    if (dut.q !== 10'h000) begin
      fails++;
      $display("FAIL reset_lfsr: q=%h, required 000", dut.q);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [9:0] e;
      e = (10'd1 << (i + 1)) - 10'd1;
      step();
      checks++;
      if (dut.q !== e) begin
        fails++;
        $display("FAIL lfsr_seq step %0d: q=%h, required %h", i + 1, dut.q, e);
      end
    end
    idle(12);
  endtask

  task automatic test_clean_press();
    for (int k = 0; k < 35; k++) begin
      key_l = (k < 20);
      step();
      checks++;
      if (L !== (k == 5) || R !== 1'b0) begin
        fails++;
        $display("FAIL clean_press k=%0d: L=%b R=%b, required L=%b R=0", k, L, R, (k == 5));
      end
    end
    key_l = 1'b0;
    idle(8);
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 30; k++) begin
      key_l = (k < 3) || (k >= 5 && k < 15);
      step();
      checks++;
      if (L !== (k == 10) || R !== 1'b0) begin
        fails++;
        $display("FAIL bounce k=%0d: L=%b R=%b, required L=%b R=0", k, L, R, (k == 10));
      end
    end
    key_l = 1'b0;
    idle(8);
  endtask

  task automatic test_cancel();
    cpu_en = 1'b0;
    for (int k = 0; k < 22; k++) begin
      key_l = (k < 10);
      key_r = (k < 10);
      step();
      checks++;
      if (L !== 1'b0 || R !== 1'b0) begin
        fails++;
        $display("FAIL cancel k=%0d: L=%b R=%b, required 0 0", k, L, R);
      end
    end
    for (int k = 0; k < 20; k++) begin
      key_l = 1'b0;
      key_r = (k < 10);
      step();
      checks++;
      if (R !== (k == 5) || L !== 1'b0) begin
        fails++;
        $display("FAIL lone_r k=%0d: L=%b R=%b, required L=0 R=%b", k, L, R, (k == 5));
      end
    end
    key_r = 1'b0;
    idle(8);
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int k = 0; k < 15; k++) begin
      key_l = 1'b1;
      step();
      checks++;
      if (L !== 1'b0 || R !== 1'b0) begin
        fails++;
        $display("FAIL freeze_hold k=%0d: L=%b R=%b, required 0 0", k, L, R);
      end
      if (k == 8) freeze = 1'b0;
    end
    key_l = 1'b0;
    idle(12);
    for (int k = 0; k < 15; k++) begin
      key_l = (k < 10);
      step();
      checks++;
      if (L !== (k == 5)) begin
        fails++;
        $display("FAIL freeze_repress k=%0d: L=%b, required %b", k, L, (k == 5));
      end
    end
    key_l = 1'b0;
    idle(8);
  endtask

  task automatic test_computer();
    logic [9:0] mq;
    logic [2:0] mpc;
    logic       mhit;
    logic       nhit;
    int         hits;
    cpu_en     = 1'b1;
    difficulty = 9'd0;
    reset      = 1'b0;
    step();
    reset = 1'b1;
    mq    = 10'h000;
    mpc   = 3'd0;
    mhit  = 1'b0;
    hits  = 0;
    for (int c = 0; c < 1000 + 8192; c++) begin
      if (c == 1000) difficulty = 9'd511;
      key_r = (c < 9000) && ((c % 40) < 20);
      step();
      nhit = (mpc == 3'd7) ? (mq < {1'b0, difficulty}) : 1'b0;
      mq   = {mq[8:0], ~(mq[9] ^ mq[6])};
      mpc  = mpc + 3'd1;
      mhit = nhit;
      if (c >= 1000 && R === 1'b1) hits++;
      checks++;
      if (R !== mhit || L !== 1'b0) begin
        fails++;
        $display("FAIL computer c=%0d diff=%0d: L=%b R=%b, required L=0 R=%b", c, difficulty, L, R, mhit);
      end
    end
    checks++;
    if (hits < 480 || hits > 544) begin
      fails++;
      $display("FAIL cpu_hit_rate: %0d hits in 1024 attempts, required 480..544", hits);
    end
    key_r  = 1'b0;
    cpu_en = 1'b0;
    idle(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_cancel();
    test_freeze();
    test_computer();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
